freq_div_ctrl: RTL and testbench

Programmable sequencer for the counter-based frequency divider. Accepts a divide ratio and pulse count through a valid/ready configuration handshake, then runs the divider for exactly that many output periods, gated cycle-by-cycle by `din`. It produces a one-cycle `tick` per divided period and a toggling `out` square wave, and reports completion or abort. It sits between a configuring master (CPU/register block or test sequencer) and the logic that consumes divided ticks.

---
 rtl/freq_div_ctrl_if.sv | 25 ++
 rtl/freq_div_ctrl.sv | 113 +++++++++++
 tb/tb_freq_div_ctrl.sv | 391 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/freq_div_ctrl_if.sv
// Configuration handshake bundle for the divider sequencer.
// The master offers div/count, the sequencer answers with ready.
interface freq_div_ctrl_if #(
    parameter int DIV_W = 8,
    parameter int CNT_W = 8
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [DIV_W-1:0] cfg_div;
    logic [CNT_W-1:0] cfg_count;

    modport master (
        output cfg_valid,
        output cfg_div,
        output cfg_count,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_div,
        input  cfg_count,
        output cfg_ready
    );
endinterface

// File: rtl/freq_div_ctrl.sv
// Programmable sequencer: runs the period counter for a configured
// number of divided periods, gated by din, with abort and done.
module freq_div_ctrl #(
    parameter int DIV_W = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    freq_div_ctrl_if.slave   cfg,
    input  logic             din,
    input  logic             abort,
    output logic             tick,
    output logic             out,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [CNT_W-1:0] pulses_left
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] pc_q, pc_d;
    logic [CNT_W-1:0] left_q, left_d;
    logic             tick_q, tick_d;
    logic             out_q, out_d;
    logic             aborted_q, aborted_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            div_q     <= '0;
            pc_q      <= '0;
            left_q    <= '0;
            tick_q    <= 1'b0;
            out_q     <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            pc_q      <= pc_d;
            left_q    <= left_d;
            tick_q    <= tick_d;
            out_q     <= out_d;
            aborted_q <= aborted_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        pc_d      = pc_q;
        left_d    = left_q;
        tick_d    = 1'b0;
        out_d     = out_q;
        aborted_d = aborted_q;
        unique case (state_q)
            S_IDLE: begin
                if (cfg.cfg_valid) begin
                    // a zero ratio behaves as divide-by-one
                    div_d = (cfg.cfg_div == '0) ?
                            DIV_W'(1) : cfg.cfg_div;
                    pc_d   = div_d - DIV_W'(1);
                    left_d = cfg.cfg_count;
                    if (cfg.cfg_count == '0)
                        state_d = S_DONE;
                    else
                        state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d   = S_DONE;
                    aborted_d = 1'b1;
                end else if (din) begin
                    if (pc_q != '0) begin
                        pc_d = pc_q - DIV_W'(1);
                    end else begin
                        tick_d = 1'b1;
                        out_d  = ~out_q;
                        pc_d   = div_q - DIV_W'(1);
                        if (left_q != '0)
                            left_d = left_q - CNT_W'(1);
                        if (left_q <= CNT_W'(1))
                            state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d   = S_IDLE;
                out_d     = 1'b0;
                aborted_d = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign cfg.cfg_ready = (state_q == S_IDLE);
    assign busy          = (state_q != S_IDLE);
    assign done          = (state_q == S_DONE);
    assign tick          = tick_q;
    assign out           = out_q;
    assign aborted       = aborted_q;
    assign pulses_left   = left_q;

endmodule

// File: tb/tb_freq_div_ctrl.sv
// Self-checking bench for freq_div_ctrl: directed scenarios plus
// random traffic against a count-of-enabled-cycles reference model.
module tb_freq_div_ctrl;

    localparam int DW = 8;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          din = 1'b0;
    logic          abort_i = 1'b0;
    logic          v = 1'b0;
    logic [DW-1:0] dv = '0;
    logic [CW-1:0] ct = '0;
    logic          tick, out_o, busy, done, aborted;
    logic [CW-1:0] pl;

    int checks = 0;
    int failures = 0;

    freq_div_ctrl_if #(.DIV_W(DW), .CNT_W(CW)) bus ();

    assign bus.cfg_valid = v;
    assign bus.cfg_div   = dv;
    assign bus.cfg_count = ct;

    freq_div_ctrl #(.DIV_W(DW), .CNT_W(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .cfg        (bus),
        .din        (din),
        .abort      (abort_i),
        .tick       (tick),
        .out        (out_o),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted),
        .pulses_left(pl)
    );

    always #5 clk = ~clk;

    // Reference: a run is K ticks, one per N enabled cycles.
    bit m_act = 0, m_done = 0, m_ab = 0;
    bit m_tick = 0, m_out = 0;
    int m_n = 1, m_k = 0, m_en = 0, m_tk = 0;

    task automatic model_edge();
        if (reset) begin
            m_act = 0; m_done = 0; m_ab = 0;
            m_tick = 0; m_out = 0;
            m_k = 0; m_tk = 0; m_n = 1; m_en = 0;
        end else if (m_done) begin
            m_done = 0; m_tick = 0; m_out = 0; m_ab = 0;
        end else if (!m_act) begin
            m_tick = 0;
            if (v) begin
                m_n  = (dv == 0) ? 1 : int'(dv);
                m_k  = int'(ct);
                m_tk = 0;
                m_en = 0;
                if (m_k == 0) m_done = 1;
                else          m_act = 1;
            end
        end else begin
            m_tick = 0;
            if (abort_i) begin
                m_act = 0; m_done = 1; m_ab = 1;
            end else if (din) begin
                m_en++;
                if (m_en % m_n == 0) begin
                    m_tk++;
                    m_tick = 1;
                    m_out = ~m_out;
                    if (m_tk == m_k) begin
                        m_act = 0; m_done = 1;
                    end
                end
            end
        end
    endtask

    function automatic logic [13:0] obs();
        return {tick, out_o, done, aborted,
                busy, bus.cfg_ready, pl};
    endfunction

    function automatic logic [13:0] expv();
        logic [7:0] left;
        left = 8'(m_k - m_tk);
        return {m_tick, m_out, m_done, m_ab,
                m_act | m_done, !(m_act | m_done), left};
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        if (obs() !== 14'b00_0001_0000_0000) begin
            failures++;
            $display("FAIL reset_state got=%b exp=%b",
                     obs(), 14'b00_0001_0000_0000);
        end
        checks++;
        reset = 1'b0;
        step();
        if (obs() !== expv()) begin
            failures++;
            $display("FAIL reset_idle got=%h exp=%h", obs(), expv());
        end
        checks++;
    endtask

    task automatic test_basic();
        logic exp_t, exp_o;
        int   exp_l;
        v = 1; dv = 4; ct = 3; din = 1;
        step();
        v = 0;
        for (int k = 1; k <= 14; k++) begin
            step();
            exp_t = (k % 4 == 0) && (k <= 12);
            exp_o = (k >= 4 && k < 8) || (k >= 12 && k < 13);
            exp_l = 3 - ((k / 4 > 3) ? 3 : k / 4);
            if (tick !== exp_t || out_o !== exp_o ||
                pl !== 8'(exp_l)) begin
                failures++;
                $display("FAIL basic_seq k=%0d got t%b o%b l%0d exp t%b o%b l%0d",
                         k, tick, out_o, pl, exp_t, exp_o, exp_l);
            end
            checks++;
            if (k == 12 && (done !== 1'b1 || aborted !== 1'b0)) begin
                failures++;
                $display("FAIL basic_done got d%b a%b exp d1 a0",
                         done, aborted);
            end
            if (k == 12) checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL basic_model k=%0d got=%h exp=%h",
                         k, obs(), expv());
            end
            checks++;
        end
    endtask

    task automatic test_div01();
        int n;
        for (int d = 0; d < 2; d++) begin
            v = 1; dv = 8'(d); ct = 5; din = 1;
            step();
            v = 0;
            n = 0;
            for (int k = 1; k <= 7; k++) begin
                step();
                if (tick === 1'b1) n++;
                if (tick !== (k <= 5)) begin
                    failures++;
                    $display("FAIL div01_tick d=%0d k=%0d got=%b exp=%b",
                             d, k, tick, (k <= 5));
                end
                checks++;
                if (obs() !== expv()) begin
                    failures++;
                    $display("FAIL div01_model k=%0d got=%h exp=%h",
                             k, obs(), expv());
                end
                checks++;
            end
            if (n != 5 || busy !== 1'b0) begin
                failures++;
                $display("FAIL div01_count d=%0d got=%0d busy=%b exp=5 busy=0",
                         d, n, busy);
            end
            checks++;
        end
    endtask

    task automatic test_count0();
        v = 1; dv = 7; ct = 0; din = 1;
        step();
        v = 0;
        if (done !== 1'b1 || tick !== 1'b0 ||
            out_o !== 1'b0 || aborted !== 1'b0) begin
            failures++;
            $display("FAIL count0_done got d%b t%b o%b a%b exp d1 t0 o0 a0",
                     done, tick, out_o, aborted);
        end
        checks++;
        step();
        if (done !== 1'b0 || bus.cfg_ready !== 1'b1) begin
            failures++;
            $display("FAIL count0_idle got d%b r%b exp d0 r1",
                     done, bus.cfg_ready);
        end
        checks++;
    endtask

    task automatic test_pause();
        logic exp_t;
        v = 1; dv = 3; ct = 2; din = 1;
        step();
        v = 0;
        for (int k = 1; k <= 10; k++) begin
            din = !(k == 2 || k == 3);
            step();
            exp_t = (k == 5 || k == 8);
            if (tick !== exp_t) begin
                failures++;
                $display("FAIL pause_tick k=%0d got=%b exp=%b",
                         k, tick, exp_t);
            end
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL pause_model k=%0d got=%h exp=%h",
                         k, obs(), expv());
            end
            checks++;
        end
        din = 1;
    endtask

    task automatic test_abort();
        v = 1; dv = 5; ct = 10; din = 1;
        step();
        dv = 2; ct = 1;
        for (int k = 1; k <= 16; k++) begin
            abort_i = (k == 10);
            step();
            if (k == 12) v = 0;
            if (k == 10 && (done !== 1 || aborted !== 1 ||
                            tick !== 0 || pl !== 8'd9)) begin
                failures++;
                $display("FAIL abort_end got d%b a%b t%b l%0d exp d1 a1 t0 l9",
                         done, aborted, tick, pl);
            end
            if (k == 11 && (busy !== 0 || pl !== 8'd9)) begin
                failures++;
                $display("FAIL abort_idle got b%b l%0d exp b0 l9",
                         busy, pl);
            end
            if (k == 12 && (busy !== 1 || pl !== 8'd1)) begin
                failures++;
                $display("FAIL abort_accept got b%b l%0d exp b1 l1",
                         busy, pl);
            end
            if (k >= 10 && k <= 12) checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL abort_model k=%0d got=%h exp=%h",
                         k, obs(), expv());
            end
            checks++;
        end
        abort_i = 0;
    endtask

    task automatic test_reset_mid();
        v = 1; dv = 3; ct = 6; din = 1;
        step();
        v = 0;
        for (int k = 1; k <= 6; k++) step();
        if (pl !== 8'd4) begin
            failures++;
            $display("FAIL rstmid_left got=%0d exp=4", pl);
        end
        checks++;
        reset = 1;
        step();
        if (obs() !== 14'b00_0001_0000_0000) begin
            failures++;
            $display("FAIL rstmid_zero got=%b exp=%b",
                     obs(), 14'b00_0001_0000_0000);
        end
        checks++;
        reset = 0; v = 1; dv = 2; ct = 1;
        step();
        v = 0;
        if (busy !== 1'b1 || pl !== 8'd1) begin
            failures++;
            $display("FAIL rstmid_accept got b%b l%0d exp b1 l1",
                     busy, pl);
        end
        checks++;
        for (int k = 0; k < 3; k++) begin
            step();
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL rstmid_model k=%0d got=%h exp=%h",
                         k, obs(), expv());
            end
            checks++;
        end
    endtask

    task automatic test_back_to_back();
        int nd = 0;
        v = 1; dv = 1; ct = 2; din = 1;
        for (int k = 0; k < 12; k++) begin
            step();
            if (done === 1'b1) nd++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL b2b_model k=%0d got=%h exp=%h",
                         k, obs(), expv());
            end
            checks++;
        end
        if (nd != 3) begin
            failures++;
            $display("FAIL b2b_runs got=%0d exp=3", nd);
        end
        checks++;
        v = 0;
        for (int k = 0; k < 4; k++) step();
    endtask

    task automatic test_maxdiv();
        int pos = -1;
        int nt = 0;
        v = 1; dv = 8'hFF; ct = 1; din = 1;
        step();
        v = 0;
        for (int k = 1; k <= 257; k++) begin
            step();
            if (tick === 1'b1) begin
                nt++;
                pos = k;
            end
        end
        if (nt != 1 || pos != 255) begin
            failures++;
            $display("FAIL maxdiv got n=%0d at=%0d exp n=1 at=255",
                     nt, pos);
        end
        checks++;
        if (obs() !== expv()) begin
            failures++;
            $display("FAIL maxdiv_model got=%h exp=%h", obs(), expv());
        end
        checks++;
    endtask

    task automatic test_random();
        for (int k = 0; k < 1500; k++) begin
            v       = ($urandom_range(0, 3) == 0);
            dv      = 8'($urandom_range(0, 5));
            ct      = 8'($urandom_range(0, 4));
            din     = ($urandom_range(0, 3) != 0);
            abort_i = ($urandom_range(0, 40) == 0);
            reset   = ($urandom_range(0, 250) == 0);
            step();
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL random k=%0d got=%h exp=%h",
                         k, obs(), expv());
            end
            checks++;
        end
        v = 0; abort_i = 0; reset = 0; din = 1;
        for (int k = 0; k < 40; k++) step();
        if (obs() !== expv()) begin
            failures++;
            $display("FAIL random_tail got=%h exp=%h", obs(), expv());
        end
        checks++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_div01();
        test_count0();
        test_pause();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        test_maxdiv();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
